ysyx_24090003_exu_pipe: RTL and testbench

YSYX_24090003_EXU_PIPE -- requirements
Module: ysyx_24090003_exu_pipe

---
 rtl/ysyx_24090003_exu_pkg.sv | 51 +++++
 rtl/ysyx_24090003_mul_iter.sv | 65 ++++++
 rtl/ysyx_24090003_exu_pipe.sv | 270 +++++++++++++++++++++++++++
 tb/tb_ysyx_24090003_exu_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090003_exu_pkg.sv
// Shared decode constants and enums for the execute unit.
//   - RV32I/RV64I major opcodes used by the execute unit
//   - funct3 / funct7 values for ALU, branch, multiply and SYSTEM decode
//   - ALU operation enum and execute FSM state enum
package ysyx_24090003_exu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;

    localparam logic [2:0] F3_PRIV = 3'b000;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_MUL, ST_HOLD
    } exu_state_e;

endpackage

// File: rtl/ysyx_24090003_mul_iter.sv
// Iterative shift-add multiplier, one partial product per clock.
//   clk, rst        : clock, synchronous active-high reset
//   start           : load operands and begin XLEN iterations
//   a, b            : operands; a_signed / b_signed select their interpretation
//   done            : high during the final iteration; product is valid then
//   product         : full 2*XLEN signed-corrected product (combinational)
module ysyx_24090003_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [2*XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              neg;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN:0]     hi_sum;
    logic [2*XLEN-1:0] mag_next;

    assign a_neg = a_signed & a[XLEN-1];
    assign b_neg = b_signed & b[XLEN-1];

    // {hi, lo} starts as {0, |b|}; each step conditionally adds |a| into the
    // upper half and shifts the whole accumulator right, consuming one
    // multiplier bit from lo[0].
    always_comb begin
        hi_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        mag_next = {hi_sum, lo[XLEN-1:1]};
    end

    assign product = neg ? -mag_next : mag_next;
    assign done    = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            neg   <= 1'b0;
        end else if (start) begin
            cnt   <= CW'(XLEN);
            mcand <= a_neg ? -a : a;
            hi    <= '0;
            lo    <= b_neg ? -b : b;
            neg   <= a_neg ^ b_neg;
        end else if (cnt != '0) begin
            cnt      <= cnt - CW'(1);
            {hi, lo} <= mag_next;
        end
    end

endmodule

// File: rtl/ysyx_24090003_exu_pipe.sv
// Execute stage: single-cycle integer ops plus an optional iterative multiply,
// with a one-entry registered result slot using valid/ready handshakes.
//   cpu_clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready           : decoded instruction handshake
//   pc, imm, rs1_data, rs2_data : operands (imm already sign-extended)
//   opcode, funct3, funct7, rd  : decode fields
//   out_valid/out_ready         : result slot handshake
//   out_rd, out_reg_wdata, out_reg_we             : register writeback
//   out_mem_addr, out_mem_wdata, out_mem_we/re/size : memory request
//   out_npc, out_ebreak, out_illegal, busy         : next PC, status, multiply busy
//
// state   | meaning
// IDLE    | can accept when the result slot is empty or draining
// MUL     | iterative multiply running, busy=1
// HOLD    | multiply result in slot, waiting for out_ready
module ysyx_24090003_exu_pipe
    import ysyx_24090003_exu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            cpu_clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [4:0]      rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_reg_wdata,
    output logic            out_reg_we,
    output logic [XLEN-1:0] out_mem_addr,
    output logic [XLEN-1:0] out_mem_wdata,
    output logic            out_mem_we,
    output logic            out_mem_re,
    output logic [2:0]      out_mem_size,
    output logic [XLEN-1:0] out_npc,
    output logic            out_ebreak,
    output logic            out_illegal,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    exu_state_e        state, state_nx;
    logic              accept;
    logic              is_mul;
    logic              mul_done;
    logic              mul_lo_sel;
    logic [2*XLEN-1:0] mul_product;
    logic [XLEN-1:0]   mul_res;

    alu_op_e           alu_op;
    logic [XLEN-1:0]   alu_b, alu_res;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   pc_4, pc_imm, addr_sum;
    logic              br_taken, br_known;

    logic [XLEN-1:0]   d_wdata, d_npc, d_addr, d_mwdata;
    logic              d_we, d_mwe, d_mre, d_ebreak, d_illegal;

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign busy     = (state == ST_MUL);
    assign accept   = in_valid && in_ready;

    assign pc_4     = pc + XLEN'(4);
    assign pc_imm   = pc + imm;
    assign addr_sum = rs1_data + imm;
    assign alu_b    = (opcode == OPC_OP) ? rs2_data : imm;
    assign shamt    = alu_b[SHW-1:0];

    // funct7[5] selects SUB (register form only) and SRA/SRAI.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            F3_ADD:  alu_op = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_res = rs1_data + alu_b;
        case (alu_op)
            ALU_ADD:  alu_res = rs1_data + alu_b;
            ALU_SUB:  alu_res = rs1_data - alu_b;
            ALU_SLL:  alu_res = rs1_data << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(alu_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_data < alu_b)};
            ALU_XOR:  alu_res = rs1_data ^ alu_b;
            ALU_SRL:  alu_res = rs1_data >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(rs1_data) >>> shamt);
            ALU_OR:   alu_res = rs1_data | alu_b;
            ALU_AND:  alu_res = rs1_data & alu_b;
            default:  alu_res = rs1_data + alu_b;
        endcase
    end

    always_comb begin
        br_known = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = (rs1_data == rs2_data);
            F3_BNE:  br_taken = (rs1_data != rs2_data);
            F3_BLT:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: br_taken = (rs1_data <  rs2_data);
            F3_BGEU: br_taken = (rs1_data >= rs2_data);
            default: br_known = 1'b0;
        endcase
    end

    always_comb begin
        d_wdata   = '0;
        d_npc     = pc_4;
        d_addr    = '0;
        d_mwdata  = '0;
        d_we      = 1'b0;
        d_mwe     = 1'b0;
        d_mre     = 1'b0;
        d_ebreak  = 1'b0;
        d_illegal = 1'b0;
        is_mul    = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_OP: begin
                if (opcode == OPC_OP && funct7 == F7_MULDIV) begin
                    if (funct3[2] || !MUL_EN) begin
                        d_illegal = 1'b1;
                    end else begin
                        is_mul = 1'b1;
                        d_we   = 1'b1;
                    end
                end else begin
                    d_wdata = alu_res;
                    d_we    = 1'b1;
                end
            end
            OPC_LUI: begin
                d_wdata = imm;
                d_we    = 1'b1;
            end
            OPC_AUIPC: begin
                d_wdata = pc_imm;
                d_we    = 1'b1;
            end
            OPC_JAL: begin
                d_wdata = pc_4;
                d_we    = 1'b1;
                d_npc   = pc_imm;
            end
            OPC_JALR: begin
                d_wdata = pc_4;
                d_we    = 1'b1;
                d_npc   = {addr_sum[XLEN-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                if (!br_known) begin
                    d_illegal = 1'b1;
                end else if (br_taken) begin
                    d_npc = pc_imm;
                end
            end
            OPC_LOAD: begin
                d_mre  = 1'b1;
                d_addr = addr_sum;
                d_we   = 1'b1;
            end
            OPC_STORE: begin
                d_mwe    = 1'b1;
                d_addr   = addr_sum;
                d_mwdata = rs2_data;
            end
            OPC_SYSTEM: begin
                if (funct3 == F3_PRIV && imm == XLEN'(1)) begin
                    d_ebreak = 1'b1;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            default: d_illegal = 1'b1;
        endcase
        if (rd == 5'd0) begin
            d_we = 1'b0;
        end
    end

    ysyx_24090003_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk      (cpu_clk),
        .rst      (rst),
        .start    (accept && is_mul),
        .a_signed ((funct3 == F3_MULH) || (funct3 == F3_MULHSU)),
        .b_signed (funct3 == F3_MULH),
        .a        (rs1_data),
        .b        (rs2_data),
        .done     (mul_done),
        .product  (mul_product)
    );

    assign mul_res = mul_lo_sel ? mul_product[XLEN-1:0] : mul_product[2*XLEN-1:XLEN];

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_nx = ST_MUL;
            ST_MUL:  if (mul_done)         state_nx = ST_HOLD;
            ST_HOLD: if (out_ready)        state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // A multiply writes its side-band fields at acceptance with out_valid low;
    // only the product is filled in when the iteration finishes.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_reg_wdata <= '0;
            out_reg_we    <= 1'b0;
            out_mem_addr  <= '0;
            out_mem_wdata <= '0;
            out_mem_we    <= 1'b0;
            out_mem_re    <= 1'b0;
            out_mem_size  <= '0;
            out_npc       <= '0;
            out_ebreak    <= 1'b0;
            out_illegal   <= 1'b0;
            mul_lo_sel    <= 1'b0;
        end else if (accept) begin
            out_valid     <= !is_mul;
            out_rd        <= rd;
            out_reg_wdata <= d_wdata;
            out_reg_we    <= d_we;
            out_mem_addr  <= d_addr;
            out_mem_wdata <= d_mwdata;
            out_mem_we    <= d_mwe;
            out_mem_re    <= d_mre;
            out_mem_size  <= funct3;
            out_npc       <= d_npc;
            out_ebreak    <= d_ebreak;
            out_illegal   <= d_illegal;
            mul_lo_sel    <= (funct3 == F3_MUL);
        end else if (state == ST_MUL && mul_done) begin
            out_valid     <= 1'b1;
            out_reg_wdata <= mul_res;
        end else if (out_valid && out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_exu_pipe.sv
module tb_ysyx_24090003_exu_pipe;
    localparam int XLEN = 32;

    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_OPIMM  = 7'b0010011;
    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_SYSTEM = 7'b1110011;

    logic            cpu_clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] pc = '0, imm = '0, rs1_data = '0, rs2_data = '0;
    logic [6:0]      opcode = '0;
    logic [2:0]      funct3 = '0;
    logic [6:0]      funct7 = '0;
    logic [4:0]      rd = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_reg_wdata, out_mem_addr, out_mem_wdata, out_npc;
    logic            out_reg_we, out_mem_we, out_mem_re, out_ebreak, out_illegal, busy;
    logic [2:0]      out_mem_size;

    ysyx_24090003_exu_pipe #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
        .cpu_clk(cpu_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_reg_wdata(out_reg_wdata), .out_reg_we(out_reg_we),
        .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
        .out_mem_we(out_mem_we), .out_mem_re(out_mem_re), .out_mem_size(out_mem_size),
        .out_npc(out_npc), .out_ebreak(out_ebreak), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } instr_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] npc;
        logic [31:0] addr;
        logic [31:0] mwdata;
        logic        mwe;
        logic        mre;
        logic [2:0]  size;
        logic        ebreak;
        logic        illegal;
        logic        is_mul;
        int          ready;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    instr_t nop = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] r, input logic [31:0] p, input logic [31:0] im,
                                  input logic [31:0] a, input logic [31:0] b);
        instr_t i;
        i.op = op; i.f3 = f3; i.f7 = f7; i.rd = r;
        i.pc = p; i.imm = im; i.rs1 = a; i.rs2 = b;
        return i;
    endfunction

    // Architectural reference: what the instruction means, not how it is built.
    function automatic exp_t model(input instr_t i);
        exp_t        e;
        logic [31:0] b, r;
        logic [63:0] ea, eb, p;
        int          sh;
        logic        t;
        e = '0;
        e.rd = i.rd; e.size = i.f3; e.npc = i.pc + 32'd4;
        r = '0; t = 1'b0;
        case (i.op)
            T_OPIMM, T_OP: begin
                b  = (i.op == T_OP) ? i.rs2 : i.imm;
                sh = int'(b[4:0]);
                if (i.op == T_OP && i.f7 == 7'h01) begin
                    if (i.f3[2]) e.illegal = 1'b1;
                    else begin
                        ea = (i.f3 == 3'd1 || i.f3 == 3'd2) ? {{32{i.rs1[31]}}, i.rs1} : {32'd0, i.rs1};
                        eb = (i.f3 == 3'd1) ? {{32{i.rs2[31]}}, i.rs2} : {32'd0, i.rs2};
                        p  = ea * eb;
                        e.wdata  = (i.f3 == 3'd0) ? p[31:0] : p[63:32];
                        e.we     = 1'b1;
                        e.is_mul = 1'b1;
                    end
                end else begin
                    case (i.f3)
                        3'd0: r = (i.op == T_OP && i.f7[5]) ? i.rs1 - b : i.rs1 + b;
                        3'd1: r = i.rs1 << sh;
                        3'd2: r = ($signed(i.rs1) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: r = (i.rs1 < b) ? 32'd1 : 32'd0;
                        3'd4: r = i.rs1 ^ b;
                        3'd5: r = i.f7[5] ? 32'($signed(i.rs1) >>> sh) : (i.rs1 >> sh);
                        3'd6: r = i.rs1 | b;
                        default: r = i.rs1 & b;
                    endcase
                    e.wdata = r; e.we = 1'b1;
                end
            end
            T_LUI:   begin e.wdata = i.imm;        e.we = 1'b1; end
            T_AUIPC: begin e.wdata = i.pc + i.imm; e.we = 1'b1; end
            T_JAL:   begin e.wdata = i.pc + 32'd4; e.we = 1'b1; e.npc = i.pc + i.imm; end
            T_JALR:  begin e.wdata = i.pc + 32'd4; e.we = 1'b1; e.npc = (i.rs1 + i.imm) & ~32'd1; end
            T_BRANCH: begin
                case (i.f3)
                    3'd0: t = (i.rs1 == i.rs2);
                    3'd1: t = (i.rs1 != i.rs2);
                    3'd4: t = ($signed(i.rs1) <  $signed(i.rs2));
                    3'd5: t = ($signed(i.rs1) >= $signed(i.rs2));
                    3'd6: t = (i.rs1 <  i.rs2);
                    3'd7: t = (i.rs1 >= i.rs2);
                    default: e.illegal = 1'b1;
                endcase
                if (t) e.npc = i.pc + i.imm;
            end
            T_LOAD:  begin e.mre = 1'b1; e.addr = i.rs1 + i.imm; e.we = 1'b1; end
            T_STORE: begin e.mwe = 1'b1; e.addr = i.rs1 + i.imm; e.mwdata = i.rs2; end
            T_SYSTEM: begin
                if (i.f3 == 3'd0 && i.imm == 32'd1) e.ebreak = 1'b1;
                else e.illegal = 1'b1;
            end
            default: e.illegal = 1'b1;
        endcase
        if (i.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic check_fields(input exp_t e);
        check("rd",        out_rd,        e.rd);
        check("reg_wdata", out_reg_wdata, e.wdata);
        check("reg_we",    out_reg_we,    e.we);
        check("npc",       out_npc,       e.npc);
        check("mem_addr",  out_mem_addr,  e.addr);
        check("mem_wdata", out_mem_wdata, e.mwdata);
        check("mem_we",    out_mem_we,    e.mwe);
        check("mem_re",    out_mem_re,    e.mre);
        check("mem_size",  out_mem_size,  e.size);
        check("ebreak",    out_ebreak,    e.ebreak);
        check("illegal",   out_illegal,   e.illegal);
    endtask

    // One clock: drive at negedge, sample 1 time unit later, then account for
    // the transfers that the next rising edge will perform.
    task automatic step(input bit iv, input instr_t ins, input bit ordy, output bit acc);
        exp_t e;
        bit   exp_valid, exp_busy, exp_ir;
        @(negedge cpu_clk);
        in_valid = iv;       opcode = ins.op;    funct3 = ins.f3;
        funct7   = ins.f7;   rd = ins.rd;        pc = ins.pc;
        imm      = ins.imm;  rs1_data = ins.rs1; rs2_data = ins.rs2;
        out_ready = ordy;
        #1;
        exp_valid = (q.size() > 0) && (cyc >= q[0].ready);
        exp_busy  = (q.size() > 0) && q[0].is_mul && (cyc < q[0].ready);
        if (q.size() == 0)   exp_ir = 1'b1;
        else if (q[0].is_mul) exp_ir = 1'b0;
        else                  exp_ir = ordy;
        check("out_valid", out_valid, exp_valid);
        check("busy", busy, exp_busy);
        check("in_ready", in_ready, exp_ir);
        if (exp_valid) check_fields(q[0]);
        acc = iv && exp_ir;
        if (exp_valid && ordy) void'(q.pop_front());
        if (acc) begin
            e = model(ins);
            e.ready = cyc + (e.is_mul ? XLEN + 1 : 1);
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic issue(input instr_t ins, input bit ordy);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, ins, ordy, acc);
            n++;
        end while (!acc && n < 200);
        check("issue_accepted", acc, 1);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, nop, ordy, acc);
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        int     k;
        i = '0;
        k = $urandom_range(0, 12);
        case (k)
            0, 1:    i.op = T_OPIMM;
            2, 3:    i.op = T_OP;
            4:       i.op = T_LUI;
            5:       i.op = T_AUIPC;
            6:       i.op = T_JAL;
            7:       i.op = T_JALR;
            8:       i.op = T_BRANCH;
            9:       i.op = T_LOAD;
            10:      i.op = T_STORE;
            11:      i.op = T_SYSTEM;
            default: i.op = 7'b1111111;
        endcase
        i.f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0, 1:    i.f7 = 7'h00;
            2:       i.f7 = 7'h20;
            default: i.f7 = (i.op == T_OP) ? 7'h01 : 7'h00;
        endcase
        i.rd  = 5'($urandom_range(0, 31));
        i.pc  = $urandom & ~32'd3;
        i.imm = $urandom;
        i.rs1 = $urandom;
        i.rs2 = ($urandom_range(0, 1) == 1) ? i.rs1 : $urandom;
        if (i.op == T_SYSTEM) begin
            i.imm = 32'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) i.f3 = 3'd0;
        end
        return i;
    endfunction

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n;
        instr_t a1, a2, a3;

        // reset state
        repeat (3) @(negedge cpu_clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_wdata", out_reg_wdata, 0);
        check("rst_npc", out_npc, 0);
        check("rst_we", out_reg_we, 0);
        check("rst_illegal", out_illegal, 0);

        // ADDI rd=5, 7 + (-3)
        issue(mk(T_OPIMM, 3'd0, 7'h00, 5'd5, 32'h8000_0000, 32'hFFFF_FFFD, 32'd7, 32'd0), 1'b1);
        step(1'b0, nop, 1'b1, acc);
        check("addi_valid", out_valid, 1);
        check("addi_wdata", out_reg_wdata, 32'd4);
        check("addi_rd", out_rd, 5'd5);
        check("addi_we", out_reg_we, 1);
        check("addi_npc", out_npc, 32'h8000_0004);

        // BEQ taken / not taken
        issue(mk(T_BRANCH, 3'd0, 7'h00, 5'd3, 32'h100, 32'h20, 32'd9, 32'd9), 1'b1);
        step(1'b0, nop, 1'b1, acc);
        check("beq_t_npc", out_npc, 32'h120);
        check("beq_t_we", out_reg_we, 0);
        issue(mk(T_BRANCH, 3'd0, 7'h00, 5'd3, 32'h100, 32'h20, 32'd9, 32'd8), 1'b1);
        step(1'b0, nop, 1'b1, acc);
        check("beq_n_npc", out_npc, 32'h104);

        // MULH and MULHU latency and result
        issue(mk(T_OP, 3'd1, 7'h01, 5'd7, 32'h200, 32'd0, 32'hFFFF_FFFF, 32'd2), 1'b1);
        n = 0;
        do begin step(1'b0, nop, 1'b1, acc); n++; end while (!out_valid && n < 100);
        check("mulh_latency", n, XLEN + 1);
        check("mulh_wdata", out_reg_wdata, 32'hFFFF_FFFF);
        issue(mk(T_OP, 3'd3, 7'h01, 5'd7, 32'h200, 32'd0, 32'hFFFF_FFFF, 32'd2), 1'b1);
        n = 0;
        do begin step(1'b0, nop, 1'b1, acc); n++; end while (!out_valid && n < 100);
        check("mulhu_latency", n, XLEN + 1);
        check("mulhu_wdata", out_reg_wdata, 32'h0000_0001);

        // back-pressure: three ADDIs, consumer stalled for 4 cycles
        a1 = mk(T_OPIMM, 3'd0, 7'h00, 5'd1, 32'h300, 32'd1, 32'd10, 32'd0);
        a2 = mk(T_OPIMM, 3'd0, 7'h00, 5'd2, 32'h304, 32'd2, 32'd10, 32'd0);
        a3 = mk(T_OPIMM, 3'd0, 7'h00, 5'd3, 32'h308, 32'd3, 32'd10, 32'd0);
        issue(a1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, a2, 1'b0, acc);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_wdata", out_reg_wdata, 32'd11);
        end
        issue(a2, 1'b1);
        issue(a3, 1'b1);
        idle(2, 1'b1);

        // EBREAK and ECALL
        issue(mk(T_SYSTEM, 3'd0, 7'h00, 5'd0, 32'h400, 32'd1, 32'd0, 32'd0), 1'b1);
        step(1'b0, nop, 1'b1, acc);
        check("ebreak_flag", out_ebreak, 1);
        check("ebreak_we", out_reg_we | out_mem_we, 0);
        issue(mk(T_SYSTEM, 3'd0, 7'h00, 5'd0, 32'h404, 32'd0, 32'd0, 32'd0), 1'b1);
        step(1'b0, nop, 1'b1, acc);
        check("ecall_illegal", out_illegal, 1);
        check("ecall_ebreak", out_ebreak, 0);

        // reset in the middle of a multiply
        issue(mk(T_OP, 3'd0, 7'h01, 5'd9, 32'h500, 32'd0, $urandom, $urandom), 1'b1);
        idle(10, 1'b1);
        check("mulrst_busy_before", busy, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge cpu_clk);
        rst = 1'b0;
        q.delete();
        cyc++;
        #1;
        check("mulrst_valid", out_valid, 0);
        check("mulrst_busy", busy, 0);
        check("mulrst_in_ready", in_ready, 1);
        idle(40, 1'b1);
        issue(mk(T_OPIMM, 3'd0, 7'h00, 5'd6, 32'h600, 32'd5, 32'd20, 32'd0), 1'b1);
        step(1'b0, nop, 1'b1, acc);
        check("mulrst_addi", out_reg_wdata, 32'd25);

        // randomized traffic against the reference model
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0, acc);
        end
        idle(60, 1'b1);
        check("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
